// File: rtl/pmux_cfg_loader.sv
// Configuration sequencer for an array of pmux4 cells: collects one 4-bit LUT
// pattern per cell, then replays them with the two-column capture protocol.
module pmux_cfg_loader #(
  parameter int NUM_CELLS = 4,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [3:0]           cfg_data,
  output logic [NUM_CELLS-1:0] prog_dat0,
  output logic [NUM_CELLS-1:0] prog_dat1,
  output logic [NUM_CELLS-1:0] prog_cap0,
  output logic [NUM_CELLS-1:0] prog_cap1,
  output logic                 done,
  output logic                 configured
);

  localparam int MAX_A   = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_A > HOLD_CYC) ? MAX_A : HOLD_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = (NUM_CELLS > 1) ? $clog2(NUM_CELLS) : 1;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  typedef enum logic [2:0] {
    S_LOAD     = 3'd0,
    S_C0_SETUP = 3'd1,
    S_C0_PULSE = 3'd2,
    S_C0_HOLD  = 3'd3,
    S_C1_SETUP = 3'd4,
    S_C1_PULSE = 3'd5,
    S_C1_HOLD  = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       pat_q [NUM_CELLS];
  logic [3:0]       pat_d [NUM_CELLS];

  logic                 cfg_ready_q, cfg_ready_d;
  logic [NUM_CELLS-1:0] prog_dat0_q, prog_dat0_d;
  logic [NUM_CELLS-1:0] prog_dat1_q, prog_dat1_d;
  logic [NUM_CELLS-1:0] prog_cap0_q, prog_cap0_d;
  logic [NUM_CELLS-1:0] prog_cap1_q, prog_cap1_d;
  logic                 done_q, done_d;
  logic                 configured_q, configured_d;

  logic hs;
  logic in_c0;
  logic in_c1;

  assign hs    = cfg_valid & cfg_ready_q;
  assign in_c0 = (state_q == S_C0_SETUP) || (state_q == S_C0_PULSE) || (state_q == S_C0_HOLD);
  assign in_c1 = (state_q == S_C1_SETUP) || (state_q == S_C1_PULSE) ||
                 (state_q == S_C1_HOLD)  || (state_q == S_DONE);

  // Next-state, phase counter, cell index and pattern capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    for (int i = 0; i < NUM_CELLS; i++) begin
      pat_d[i] = pat_q[i];
    end
    case (state_q)
      S_LOAD: begin
        if (hs) begin
          for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx_q == IDX_W'(i)) begin
              pat_d[i] = cfg_data;
            end else begin
              pat_d[i] = pat_q[i];
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_C0_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      S_C0_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_C0_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_C0_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_C0_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_C0_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_C1_SETUP;
          cnt_d   = SETUP_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_C1_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_C1_PULSE;
          cnt_d   = PULSE_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_C1_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_C1_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_C1_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_LOAD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output decode: pins follow the state one cycle late, so data leads each strobe by the full setup time.
  always_comb begin
    cfg_ready_d  = (state_d == S_LOAD);
    prog_dat0_d  = '0;
    prog_dat1_d  = '0;
    prog_cap0_d  = (state_q == S_C0_PULSE) ? {NUM_CELLS{1'b1}} : {NUM_CELLS{1'b0}};
    prog_cap1_d  = (state_q == S_C1_PULSE) ? {NUM_CELLS{1'b1}} : {NUM_CELLS{1'b0}};
    done_d       = (state_q == S_DONE);
    configured_d = configured_q;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (in_c0) begin
        prog_dat0_d[i] = pat_q[i][0];
        prog_dat1_d[i] = pat_q[i][2];
      end else if (in_c1) begin
        prog_dat0_d[i] = pat_q[i][1];
        prog_dat1_d[i] = pat_q[i][3];
      end else begin
        prog_dat0_d[i] = 1'b0;
        prog_dat1_d[i] = 1'b0;
      end
    end
    if (state_q == S_DONE) begin
      configured_d = 1'b1;
    end else if (hs && (idx_q == '0)) begin
      configured_d = 1'b0;
    end else begin
      configured_d = configured_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      cnt_q        <= '0;
      idx_q        <= '0;
      for (int i = 0; i < NUM_CELLS; i++) begin
        pat_q[i] <= 4'h0;
      end
      cfg_ready_q  <= 1'b0;
      prog_dat0_q  <= '0;
      prog_dat1_q  <= '0;
      prog_cap0_q  <= '0;
      prog_cap1_q  <= '0;
      done_q       <= 1'b0;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      for (int i = 0; i < NUM_CELLS; i++) begin
        pat_q[i] <= pat_d[i];
      end
      cfg_ready_q  <= cfg_ready_d;
      prog_dat0_q  <= prog_dat0_d;
      prog_dat1_q  <= prog_dat1_d;
      prog_cap0_q  <= prog_cap0_d;
      prog_cap1_q  <= prog_cap1_d;
      done_q       <= done_d;
      configured_q <= configured_d;
    end
  end

  assign cfg_ready  = cfg_ready_q;
  assign prog_dat0  = prog_dat0_q;
  assign prog_dat1  = prog_dat1_q;
  assign prog_cap0  = prog_cap0_q;
  assign prog_cap1  = prog_cap1_q;
  assign done       = done_q;
  assign configured = configured_q;

endmodule

// File: tb/tb_pmux_cfg_loader.sv
// Bench for pmux_cfg_loader: two instances (4 cells default timing, 1 cell 3/1/2 timing),
// directed literal checks plus randomized traffic against a cycle-offset reference model.
module tb_pmux_cfg_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance A: defaults
  logic       rst_a, valid_a, ready_a, done_a, conf_a;
  logic [3:0] data_a, d0_a, d1_a, c0_a, c1_a;
  // Instance B: one cell, setup 3, pulse 1, hold 2
  logic       rst_b, valid_b, ready_b, done_b, conf_b;
  logic [3:0] data_b;
  logic [0:0] d0_b, d1_b, c0_b, c1_b;

  pmux_cfg_loader u_a (
    .clk(clk), .rst(rst_a), .cfg_valid(valid_a), .cfg_ready(ready_a), .cfg_data(data_a),
    .prog_dat0(d0_a), .prog_dat1(d1_a), .prog_cap0(c0_a), .prog_cap1(c1_a),
    .done(done_a), .configured(conf_a)
  );

  pmux_cfg_loader #(.NUM_CELLS(1), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(2)) u_b (
    .clk(clk), .rst(rst_b), .cfg_valid(valid_b), .cfg_ready(ready_b), .cfg_data(data_b),
    .prog_dat0(d0_b), .prog_dat1(d1_b), .prog_cap0(c0_b), .prog_cap1(c1_b),
    .done(done_b), .configured(conf_b)
  );

  // Reference model: k counts edges since the final handshake of a load.
  typedef struct packed {
    logic [15:0] pats;
    int          n;
    bit          busy;
    int          k;
    int          kout;
    bit          rdy;
    bit          conf;
  } mdl_t;

  typedef struct packed {
    logic [3:0] d0;
    logic [3:0] d1;
    logic [3:0] c0;
    logic [3:0] c1;
    logic       dn;
  } exp_t;

  mdl_t ma, mb;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", nm, $time, got, exp);
    end
  endtask

  task automatic mstep(inout mdl_t m, input int nc, input int t, input bit r, input bit v,
                       input logic [3:0] d);
    if (r) begin
      m.n = 0; m.busy = 1'b0; m.k = 0; m.kout = 0; m.rdy = 1'b0; m.conf = 1'b0;
    end else begin
      m.kout = 0;
      if (m.busy) begin
        m.k    = m.k + 1;
        m.kout = m.k;
        if (m.k == 2 * t + 1) m.busy = 1'b0;
      end else if (m.rdy && v) begin
        if (m.n == 0) m.conf = 1'b0;
        m.pats[m.n*4 +: 4] = d;
        m.n = m.n + 1;
        if (m.n == nc) begin
          m.n = 0; m.busy = 1'b1; m.k = 0;
        end
      end
      if (m.kout == 2 * t + 1) m.conf = 1'b1;
      m.rdy = !m.busy;
    end
  endtask

  function automatic exp_t mexp(mdl_t m, int nc, int s, int p, int h);
    exp_t e;
    int t, col, sub;
    e = '0;
    t = s + p + h;
    if (m.kout != 0) begin
      col = (m.kout <= t) ? 0 : 1;
      sub = (col == 0) ? m.kout : m.kout - t;
      for (int i = 0; i < nc; i++) begin
        e.d0[i] = m.pats[4*i + col];
        e.d1[i] = m.pats[4*i + col + 2];
        if (sub > s && sub <= s + p) begin
          if (col == 0) e.c0[i] = 1'b1;
          else          e.c1[i] = 1'b1;
        end
      end
      e.dn = (m.kout == 2 * t + 1);
    end
    return e;
  endfunction

  // Compare process: step the models with the inputs seen at the last edge, then check every output.
  initial begin
    exp_t ea, eb;
    ma = '0;
    mb = '0;
    forever begin
      @(negedge clk);
      mstep(ma, 4, 4, rst_a, valid_a, data_a);
      mstep(mb, 1, 6, rst_b, valid_b, data_b);
      ea = mexp(ma, 4, 1, 2, 1);
      eb = mexp(mb, 1, 3, 1, 2);
      chk("a_ready", 32'(ready_a), 32'(ma.rdy));
      chk("a_conf",  32'(conf_a),  32'(ma.conf));
      chk("a_done",  32'(done_a),  32'(ea.dn));
      chk("a_dat0",  32'(d0_a),    32'(ea.d0));
      chk("a_dat1",  32'(d1_a),    32'(ea.d1));
      chk("a_cap0",  32'(c0_a),    32'(ea.c0));
      chk("a_cap1",  32'(c1_a),    32'(ea.c1));
      chk("b_ready", 32'(ready_b), 32'(mb.rdy));
      chk("b_conf",  32'(conf_b),  32'(mb.conf));
      chk("b_done",  32'(done_b),  32'(eb.dn));
      chk("b_dat0",  32'(d0_b),    32'(eb.d0));
      chk("b_dat1",  32'(d1_b),    32'(eb.d1));
      chk("b_cap0",  32'(c0_b),    32'(eb.c0));
      chk("b_cap1",  32'(c1_b),    32'(eb.c1));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic load_a();
    logic [3:0] pats [4];
    pats[0] = 4'hE; pats[1] = 4'h8; pats[2] = 4'h9; pats[3] = 4'h1;
    for (int i = 0; i < 4; i++) begin
      chk("a_lit_ready_load", 32'(ready_a), 32'd1);
      valid_a = 1'b1;
      data_a  = pats[i];
      step();
    end
  endtask

  // Stimulus: directed sequences with literal expectations, then randomized traffic.
  initial begin
    rst_a = 1'b1; valid_a = 1'b1; data_a = 4'h3;
    rst_b = 1'b1; valid_b = 1'b1; data_b = 4'h3;
    repeat (3) begin
      step();
      chk("a_lit_rst_ready", 32'(ready_a), 32'd0);
      chk("a_lit_rst_prog",  32'({d0_a, d1_a, c0_a, c1_a}), 32'd0);
    end
    rst_a = 1'b0; valid_a = 1'b0;
    rst_b = 1'b0; valid_b = 1'b0;
    step();
    chk("a_lit_ready_after_rst", 32'(ready_a), 32'd1);
    chk("b_lit_ready_after_rst", 32'(ready_b), 32'd1);

    // Load 0xE,0x8,0x9,0x1; beats offered during programming must be ignored.
    load_a();
    for (int j = 0; j <= 10; j++) begin
      if (j == 0) chk("a_lit_ready_drop", 32'(ready_a), 32'd0);
      if (j == 2 || j == 3) begin
        chk("a_lit_c0_cap0", 32'(c0_a), 32'hF);
        chk("a_lit_c0_dat0", 32'(d0_a), 32'hC);
        chk("a_lit_c0_dat1", 32'(d1_a), 32'h1);
      end
      if (j == 4) chk("a_lit_c0_capfall", 32'(c0_a), 32'h0);
      if (j == 6 || j == 7) begin
        chk("a_lit_c1_cap1", 32'(c1_a), 32'hF);
        chk("a_lit_c1_dat0", 32'(d0_a), 32'h1);
        chk("a_lit_c1_dat1", 32'(d1_a), 32'h7);
      end
      if (j == 8) chk("a_lit_done_early", 32'(done_a), 32'd0);
      if (j == 9) begin
        chk("a_lit_done", 32'(done_a), 32'd1);
        chk("a_lit_configured", 32'(conf_a), 32'd1);
      end
      if (j == 10) chk("a_lit_done_once", 32'(done_a), 32'd0);
      valid_a = (j < 9);
      data_a  = 4'($urandom_range(0, 15));
      step();
    end

    // Reload, then reset in the middle of the column-0 pulse.
    chk("a_lit_conf_before_reload", 32'(conf_a), 32'd1);
    load_a();
    valid_a = 1'b0;
    chk("a_lit_conf_cleared", 32'(conf_a), 32'd0);
    step();
    step();
    chk("a_lit_c0_cap0_pre_rst", 32'(c0_a), 32'hF);
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    chk("a_lit_rst_cap0", 32'(c0_a), 32'h0);
    chk("a_lit_rst_conf", 32'(conf_a), 32'd0);
    step();

    // Instance B: single cell, pattern 0101, 13-cycle occupancy.
    valid_b = 1'b1;
    data_b  = 4'h5;
    step();
    for (int j = 0; j <= 14; j++) begin
      if (j == 0) chk("b_lit_ready_drop", 32'(ready_b), 32'd0);
      if (j >= 1 && j <= 6) chk("b_lit_c0_dat0", 32'(d0_b), 32'd1);
      if (j == 4) chk("b_lit_cap0", 32'(c0_b), 32'd1);
      if (j == 5) chk("b_lit_cap0_fall", 32'(c0_b), 32'd0);
      if (j == 7) chk("b_lit_c1_dat0", 32'(d0_b), 32'd0);
      if (j == 10) chk("b_lit_cap1", 32'(c1_b), 32'd1);
      if (j == 11) chk("b_lit_cap1_fall", 32'(c1_b), 32'd0);
      if (j == 12) chk("b_lit_done_early", 32'(done_b), 32'd0);
      if (j == 13) chk("b_lit_done", 32'(done_b), 32'd1);
      valid_b = (j < 13);
      data_b  = 4'($urandom_range(0, 15));
      step();
    end

    // Randomized traffic: back-to-back, alternate-cycle and random valid, rare resets.
    for (int c = 0; c < 4000; c++) begin
      int mode;
      mode = (c / 250) % 3;
      valid_a = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
      valid_b = (mode == 1) ? 1'b1 : (mode == 2) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
      data_a  = 4'($urandom_range(0, 15));
      data_b  = 4'($urandom_range(0, 15));
      rst_a   = ($urandom_range(0, 299) == 0);
      rst_b   = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_a = 1'b0; rst_b = 1'b0; valid_a = 1'b0; valid_b = 1'b0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
